// File: rtl/mux_ser_pkg.sv
// Shared types and sizing helpers for the mux scan serializer.
// The frame FSM enum and counter widths are defined here.
package mux_ser_pkg;

  localparam int SEL_W  = 3;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

  // The divider needs at least one bit, even when BIT_CYC is 1.
  function automatic int div_w(input int bit_cyc);
    return (bit_cyc <= 2) ? 1 : $clog2(bit_cyc);
  endfunction

endpackage

// File: rtl/bit_period_cnt.sv
// Bit-period divider: a sample flag on the first cycle of each bit period
// and a tick flag on the last cycle. The count clears when a frame starts.
module bit_period_cnt
  import mux_ser_pkg::*;
#(
  parameter int BIT_CYC = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic en,
  output logic sample,
  output logic tick
);

  localparam int CW = div_w(BIT_CYC);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

  logic [CW-1:0] div_cnt_reg, div_cnt_next;
  logic          at_last;

  assign at_last = (div_cnt_reg == LAST);
  assign sample  = en && (div_cnt_reg == '0);
  assign tick    = en && at_last;

  // When BIT_CYC is 1, at_last is always true, so the count stays at zero.
  always_comb begin
    div_cnt_next = div_cnt_reg;
    if (clear) begin
      div_cnt_next = '0;
    end else if (en) begin
      div_cnt_next = at_last ? '0 : div_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_next;
    end
  end

endmodule

// File: rtl/mux_scan_serializer.sv
// Frame controller around an external 8:1 mux. It captures a word, walks the
// mux select, and turns the mux output into a registered serial stream.
module mux_scan_serializer
  import mux_ser_pkg::*;
#(
  parameter int BIT_CYC   = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] mux_data,
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_out,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              done,
  output logic              parity
);

  localparam logic [SEL_W-1:0] SEL_FIRST = (MSB_FIRST != 0) ? 3'd7 : 3'd0;

  ser_state_t        state_reg, state_next;
  logic [DATA_W-1:0] mux_data_reg, mux_data_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic              ser_out_reg, ser_out_next;
  logic              ser_valid_reg, ser_valid_next;
  logic              parity_reg, parity_next;
  logic              frame_start;
  logic              sample;
  logic              tick;

  bit_period_cnt #(
    .BIT_CYC(BIT_CYC)
  ) u_bit_period_cnt (
    .clk   (sys_clk),
    .srst  (sys_rst),
    .clear (frame_start),
    .en    (state_reg == SHIFT),
    .sample(sample),
    .tick  (tick)
  );

  always_comb begin
    state_next     = state_reg;
    mux_data_next  = mux_data_reg;
    sel_next       = sel_reg;
    bit_cnt_next   = bit_cnt_reg;
    ser_out_next   = ser_out_reg;
    ser_valid_next = 1'b0;
    parity_next    = parity_reg;
    frame_start    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          frame_start   = 1'b1;
          mux_data_next = din;
          sel_next      = SEL_FIRST;
          bit_cnt_next  = 3'd0;
          parity_next   = 1'b0;
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        if (sample) begin
          ser_out_next   = mux_out;
          ser_valid_next = 1'b1;
          parity_next    = parity_reg ^ mux_out;
        end
        // sel stops on the last position instead of wrapping.
        if (tick) begin
          if (bit_cnt_reg == 3'd7) begin
            state_next = DONE;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            sel_next     = (MSB_FIRST != 0) ? sel_reg - 3'd1 : sel_reg + 3'd1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg     <= IDLE;
      mux_data_reg  <= '0;
      sel_reg       <= '0;
      bit_cnt_reg   <= 3'd0;
      ser_out_reg   <= 1'b0;
      ser_valid_reg <= 1'b0;
      parity_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mux_data_reg  <= mux_data_next;
      sel_reg       <= sel_next;
      bit_cnt_reg   <= bit_cnt_next;
      ser_out_reg   <= ser_out_next;
      ser_valid_reg <= ser_valid_next;
      parity_reg    <= parity_next;
    end
  end

  assign mux_data  = mux_data_reg;
  assign sel       = sel_reg;
  assign ser_out   = ser_out_reg;
  assign ser_valid = ser_valid_reg;
  assign parity    = parity_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);

endmodule
